// File: rtl/tinsel_msg_assembler.sv
// rtl/tinsel_msg_assembler.sv - reassembles a flit stream into whole multi-flit messages
//
// Purpose:
//   Consumes one Flit per beat on a valid/ready port and packs the payloads of a
//   message into one wide word. A message ends at the first flit with
//   notFinalFlit == 0. The assembled message is then held on a valid/ready
//   message port until the consumer takes it. All state updates on the falling
//   clock edge.
//
// Configuration macro:
//   TINSEL_MSG_ASSEMBLER_IDLE_EN - when defined, an idle-token flit arriving at
//   slot 0 becomes a one-slot message flagged with msg_idle. When undefined,
//   every idle-token flit is consumed and dropped, and msg_idle is tied to 0.
//
// Ports:
//   clk          in   clock (falling edge active)
//   rst          in   asynchronous active-high reset
//   in_data      in   incoming Flit
//   in_valid     in   flit present
//   in_ready     out  flit accepted this cycle (high while collecting)
//   msg_data     out  MAX_FLITS payload slots, flit 0 in the least-significant slot
//   msg_dest     out  destination taken from flit 0
//   msg_len      out  payload slots filled, 1..MAX_FLITS while msg_valid
//   msg_overflow out  message had more than MAX_FLITS flits, excess discarded
//   msg_idle     out  message is an idle token
//   msg_valid    out  assembled message available
//   msg_ready    in   consumer takes the message

package tinsel_msg_pkg;
  localparam int TinselBitsPerFlit = 64;

  typedef struct packed {
    logic       acc;
    logic       host;
    logic [2:0] board_y;
    logic [2:0] board_x;
    logic [3:0] mbox;
    logic [3:0] thread;
  } NetAddr;

  typedef struct packed {
    NetAddr                         dest;
    logic                           notFinalFlit;
    logic                           isIdleToken;
    logic [TinselBitsPerFlit-1:0]   payload;
  } Flit;
endpackage

module tinsel_msg_assembler
  import tinsel_msg_pkg::*;
#(
  parameter int MAX_FLITS = 4,
  parameter int LEN_BITS  = $clog2(MAX_FLITS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [$bits(Flit)-1:0]               in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [MAX_FLITS*TinselBitsPerFlit-1:0] msg_data,
  output logic [$bits(NetAddr)-1:0]            msg_dest,
  output logic [LEN_BITS-1:0]                  msg_len,
  output logic                                 msg_overflow,
  output logic                                 msg_idle,
  output logic                                 msg_valid,
  input  logic                                 msg_ready
);
  localparam int BPF = TinselBitsPerFlit;
  localparam logic [LEN_BITS-1:0] MAX_IDX = LEN_BITS'(MAX_FLITS);

  typedef enum logic {S_COLLECT, S_PRESENT} state_t;

  state_t                   r_state;
  logic                     r_in_ready;
  logic                     r_msg_valid;
  logic [LEN_BITS-1:0]      r_idx;
  logic [MAX_FLITS*BPF-1:0] r_data;
  NetAddr                   r_dest;
  logic                     r_overflow;

  Flit  w_flit;
  logic w_accept;
  logic w_drop;
  logic w_force_final;

  assign w_flit   = in_data;
  assign w_accept = in_valid && r_in_ready;

`ifdef TINSEL_MSG_ASSEMBLER_IDLE_EN
  logic r_idle;
  // An idle token opening a message is a complete message on its own; one
  // arriving mid-message is swallowed so the partial message is untouched.
  assign w_force_final = w_flit.isIdleToken && (r_idx == '0);
  assign w_drop        = w_flit.isIdleToken && (r_idx != '0);
  assign msg_idle      = r_idle;
`else
  assign w_force_final = 1'b0;
  assign w_drop        = w_flit.isIdleToken;
  assign msg_idle      = 1'b0;
`endif

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_in_ready  <= 1'b1;
      r_msg_valid <= 1'b0;
      r_idx       <= '0;
      r_data      <= '0;
      r_dest      <= '0;
      r_overflow  <= 1'b0;
`ifdef TINSEL_MSG_ASSEMBLER_IDLE_EN
      r_idle      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept && !w_drop) begin
            if (r_idx == '0) begin
              r_dest <= w_flit.dest;
            end
            // idx saturates at MAX_FLITS; once there, payloads are discarded
            // and the count doubles as the final msg_len.
            if (r_idx < MAX_IDX) begin
              for (int s = 0; s < MAX_FLITS; s++) begin
                if (r_idx == LEN_BITS'(s)) begin
                  r_data[s*BPF +: BPF] <= w_flit.payload;
                end
              end
              r_idx <= r_idx + LEN_BITS'(1);
            end else begin
              r_overflow <= 1'b1;
            end
            if (w_force_final || !w_flit.notFinalFlit) begin
              r_state     <= S_PRESENT;
              r_in_ready  <= 1'b0;
              r_msg_valid <= 1'b1;
`ifdef TINSEL_MSG_ASSEMBLER_IDLE_EN
              r_idle      <= w_force_final;
`endif
            end
          end
        end
        S_PRESENT: begin
          if (msg_ready) begin
            // Slots are cleared here so unfilled slots of the next message read 0.
            r_state     <= S_COLLECT;
            r_in_ready  <= 1'b1;
            r_msg_valid <= 1'b0;
            r_idx       <= '0;
            r_data      <= '0;
            r_overflow  <= 1'b0;
`ifdef TINSEL_MSG_ASSEMBLER_IDLE_EN
            r_idle      <= 1'b0;
`endif
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign msg_valid    = r_msg_valid;
  assign msg_data     = r_data;
  assign msg_dest     = r_dest;
  assign msg_len      = r_idx;
  assign msg_overflow = r_overflow;

endmodule

// File: tb/tb_tinsel_msg_assembler.sv
// tb/tb_tinsel_msg_assembler.sv - self-checking bench for tinsel_msg_assembler
module tb_tinsel_msg_assembler;
  import tinsel_msg_pkg::*;

  localparam int MF   = 4;
  localparam int LB   = 3;
  localparam int BPF  = TinselBitsPerFlit;
  localparam int NMSG = 1000;
  localparam int LIMIT = 40000;

  logic                    clk;
  logic                    rst;
  logic [$bits(Flit)-1:0]  in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [MF*BPF-1:0]       msg_data;
  logic [15:0]             msg_dest;
  logic [LB-1:0]           msg_len;
  logic                    msg_overflow;
  logic                    msg_idle;
  logic                    msg_valid;
  logic                    msg_ready;

  int n_checks = 0;
  int n_err    = 0;

  tinsel_msg_assembler #(.MAX_FLITS(MF)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .msg_data     (msg_data),
    .msg_dest     (msg_dest),
    .msg_len      (msg_len),
    .msg_overflow (msg_overflow),
    .msg_idle     (msg_idle),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic          nf;
    logic          idl;
    logic [15:0]   dst;
    logic [63:0]   pay;
    logic          rdy;
    logic          e_ir;
    logic          e_mv;
    logic [2:0]    e_len;
    logic          e_ovf;
    logic [15:0]   e_dst;
    logic          e_clr;
    logic [255:0]  e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] P(input int k);
    return {32'hC0DE0000 + 32'(k), 32'hFACE0000 + 32'(k)};
  endfunction

  function automatic Flit mkf(input logic [15:0] dst, input logic nf, input logic idl,
                              input logic [63:0] pay);
    Flit f;
    f.dest         = NetAddr'(dst);
    f.notFinalFlit = nf;
    f.isIdleToken  = idl;
    f.payload      = pay;
    return f;
  endfunction

  function automatic vec_t mkv(input logic vld, input logic nf, input logic idl,
                               input logic [15:0] dst, input logic [63:0] pay, input logic rdy,
                               input logic e_ir, input logic e_mv, input logic [2:0] e_len,
                               input logic e_ovf, input logic [15:0] e_dst, input logic e_clr,
                               input logic [255:0] e_data);
    vec_t v;
    v.vld = vld; v.nf = nf; v.idl = idl; v.dst = dst; v.pay = pay; v.rdy = rdy;
    v.e_ir = e_ir; v.e_mv = e_mv; v.e_len = e_len; v.e_ovf = e_ovf; v.e_dst = e_dst;
    v.e_clr = e_clr; v.e_data = e_data;
    return v;
  endfunction

  // Drive inputs, let one falling edge happen, return just after the next rising edge.
  task automatic step(input logic v, input Flit f, input logic r);
    in_valid  = v;
    in_data   = f;
    msg_ready = r;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_msg_valid"}, msg_valid, 0);
    chk({tag, "_msg_len"}, msg_len, 0);
    chk({tag, "_overflow"}, msg_overflow, 0);
    chk({tag, "_idle"}, msg_idle, 0);
    chk({tag, "_dest"}, msg_dest, 0);
    chk({tag, "_data"}, msg_data, 0);
  endtask

  task automatic run_table();
    logic [63:0] z;
    z = 64'h0;
    // single flit, consumer always ready
    vecs.push_back(mkv(1,0,0,16'h0123,P(0),1, 0,1,1,0,16'h0123,0,{z,z,z,P(0)}));
    vecs.push_back(mkv(0,0,0,16'h0000,z,1,    1,0,0,0,16'h0,1,'0));
    // three flits with continuous valid, consumer stalls five cycles
    vecs.push_back(mkv(1,1,0,16'h0200,P(1),0, 1,0,0,0,16'h0,0,'0));
    vecs.push_back(mkv(1,1,0,16'h0BAD,P(2),0, 1,0,0,0,16'h0,0,'0));
    vecs.push_back(mkv(1,0,0,16'h0BAD,P(3),0, 0,1,3,0,16'h0200,0,{z,P(3),P(2),P(1)}));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkv(1,0,0,16'h0300,P(4),0, 0,1,3,0,16'h0200,0,{z,P(3),P(2),P(1)}));
    vecs.push_back(mkv(1,0,0,16'h0300,P(4),1, 1,0,0,0,16'h0,1,'0));
    vecs.push_back(mkv(1,0,0,16'h0300,P(4),1, 0,1,1,0,16'h0300,0,{z,z,z,P(4)}));
    vecs.push_back(mkv(0,0,0,16'h0000,z,1,    1,0,0,0,16'h0,1,'0));
    // six-flit message into four slots
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkv(1,1,0,(i == 0) ? 16'h0401 : 16'h0999,P(10+i),0, 1,0,0,0,16'h0,0,'0));
    vecs.push_back(mkv(1,0,0,16'h0999,P(15),0, 0,1,4,1,16'h0401,0,{P(13),P(12),P(11),P(10)}));
    vecs.push_back(mkv(0,0,0,16'h0000,z,1,    1,0,0,0,16'h0,1,'0));
    vecs.push_back(mkv(1,0,0,16'h0402,P(16),0, 0,1,1,0,16'h0402,0,{z,z,z,P(16)}));
    vecs.push_back(mkv(0,0,0,16'h0000,z,1,    1,0,0,0,16'h0,1,'0));
    // idle token in the middle of a message is swallowed
    vecs.push_back(mkv(1,1,0,16'h0501,P(20),0, 1,0,0,0,16'h0,0,'0));
    vecs.push_back(mkv(1,0,1,16'h0666,P(21),0, 1,0,0,0,16'h0,0,'0));
    vecs.push_back(mkv(1,0,0,16'h0777,P(22),0, 0,1,2,0,16'h0501,0,{z,z,P(22),P(20)}));
    vecs.push_back(mkv(0,0,0,16'h0000,z,1,    1,0,0,0,16'h0,1,'0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vld, mkf(vecs[i].dst, vecs[i].nf, vecs[i].idl, vecs[i].pay), vecs[i].rdy);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("vec%0d_msg_valid", i), msg_valid, vecs[i].e_mv);
      if (vecs[i].e_mv) begin
        chk($sformatf("vec%0d_len", i), msg_len, vecs[i].e_len);
        chk($sformatf("vec%0d_dest", i), msg_dest, vecs[i].e_dst);
        chk($sformatf("vec%0d_data", i), msg_data, vecs[i].e_data);
        chk($sformatf("vec%0d_overflow", i), msg_overflow, vecs[i].e_ovf);
        chk($sformatf("vec%0d_idle", i), msg_idle, 0);
      end
      if (vecs[i].e_clr) begin
        chk($sformatf("vec%0d_clr_data", i), msg_data, 0);
        chk($sformatf("vec%0d_clr_overflow", i), msg_overflow, 0);
        chk($sformatf("vec%0d_clr_idle", i), msg_idle, 0);
      end
    end
  endtask

  task automatic run_idle_head();
`ifdef TINSEL_MSG_ASSEMBLER_IDLE_EN
    step(1, mkf(16'h0700, 1, 1, P(30)), 0);
    chk("idle_msg_valid", msg_valid, 1);
    chk("idle_flag", msg_idle, 1);
    chk("idle_len", msg_len, 1);
    chk("idle_data", msg_data, {192'h0, P(30)});
    step(0, mkf(16'h0, 0, 0, 64'h0), 1);
    chk("idle_release", msg_valid, 0);
    chk("idle_flag_clr", msg_idle, 0);
`else
    step(1, mkf(16'h0700, 0, 1, P(30)), 0);
    chk("idle_drop_valid", msg_valid, 0);
    chk("idle_drop_ready", in_ready, 1);
    step(1, mkf(16'h0701, 0, 0, P(31)), 0);
    chk("idle_next_valid", msg_valid, 1);
    chk("idle_next_len", msg_len, 1);
    chk("idle_next_dest", msg_dest, 16'h0701);
    chk("idle_next_data", msg_data, {192'h0, P(31)});
    chk("idle_next_flag", msg_idle, 0);
    step(0, mkf(16'h0, 0, 0, 64'h0), 1);
    chk("idle_next_release", msg_valid, 0);
`endif
  endtask

  task automatic run_reset_mid();
    step(1, mkf(16'h0801, 1, 0, P(40)), 0);
    step(1, mkf(16'h0802, 1, 0, P(41)), 0);
    in_valid = 1;
    in_data  = mkf(16'h0803, 0, 0, P(42));
    #1 rst = 1;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst = 0;
    step(1, mkf(16'h0812, 0, 0, P(43)), 0);
    chk("midrst_after_valid", msg_valid, 1);
    chk("midrst_after_len", msg_len, 1);
    chk("midrst_after_dest", msg_dest, 16'h0812);
    chk("midrst_after_data", msg_data, {192'h0, P(43)});
    step(0, mkf(16'h0, 0, 0, 64'h0), 1);
    chk("midrst_after_release", msg_valid, 0);
  endtask

  // Random backpressure against a message-level model: each expected message is
  // just its first destination, its flit count and its payloads packed by index.
  task automatic run_random();
    Flit           flits[$];
    logic [2:0]    e_len[$];
    logic [15:0]   e_dst[$];
    logic [255:0]  e_dat[$];
    int fi, mi, cyc;
    logic acc, hs;
    for (int m = 0; m < NMSG; m++) begin
      int len;
      logic [15:0]  d;
      logic [255:0] w;
      len = $urandom_range(1, MF);
      d   = 16'($urandom);
      w   = '0;
      for (int k = 0; k < len; k++) begin
        logic [63:0] p;
        p = {$urandom, $urandom};
        w[k*BPF +: BPF] = p;
        flits.push_back(mkf((k == 0) ? d : 16'($urandom), (k != len - 1), 1'b0, p));
      end
      e_len.push_back(3'(len));
      e_dst.push_back(d);
      e_dat.push_back(w);
    end
    fi = 0; mi = 0; cyc = 0;
    in_valid = 0;
    while ((mi < NMSG || fi < flits.size()) && cyc < LIMIT) begin
      if (fi < flits.size()) begin
        if (!in_valid) in_valid = ($urandom_range(0, 3) != 0);
        in_data = flits[fi];
      end else begin
        in_valid = 0;
      end
      msg_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && in_ready;
      hs  = msg_valid && msg_ready;
      if (hs) begin
        if (mi < NMSG) begin
          chk($sformatf("rnd_msg%0d", mi),
              {msg_len, msg_dest, msg_overflow, msg_idle, msg_data},
              {e_len[mi], e_dst[mi], 1'b0, 1'b0, e_dat[mi]});
        end else begin
          chk("rnd_extra_msg", 1, 0);
        end
        mi++;
      end
      @(negedge clk);
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        fi++;
        in_valid = 0;
      end
    end
    chk("rnd_msg_count", mi, NMSG);
    chk("rnd_flit_count", fi, flits.size());
    in_valid  = 0;
    msg_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1;
    in_valid  = 0;
    in_data   = '0;
    msg_ready = 0;
    @(negedge clk);
    #1;
    check_reset("por");
    @(posedge clk);
    #1;
    rst = 0;
    run_table();
    run_idle_head();
    run_reset_mid();
    run_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
